// File: rtl/beep_decode.sv
// Beep line decoder: classifies a sampled square wave into low tone, high tone
// or silence, counts confirmed tone segments and flags the end of a sequence.
module beep_decode #(
  parameter int HI_HALF    = 1,
  parameter int LO_HALF    = 2,
  parameter int CONF       = 4,
  parameter int SIL_LIM    = 16,
  parameter int EXPECT_SEG = 4
) (
  input  logic       clk,
  input  logic       st,
  input  logic       beep_in,
  output logic [1:0] tone,
  output logic       tone_chg,
  output logic [3:0] seg_cnt,
  output logic       err,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0] HI_LEN  = 8'(HI_HALF);
  localparam logic [7:0] LO_LEN  = 8'(LO_HALF);
  localparam logic [7:0] SIL_LEN = 8'(SIL_LIM);
  localparam logic [3:0] CONF_N  = 4'(CONF);
  localparam logic [3:0] EXP_N   = 4'(EXPECT_SEG);

  logic       s1_r;
  logic       s2_r;
  logic       p_r;
  logic [7:0] run_len_r;
  logic       first_edge_r;
  logic [1:0] cand_r;
  logic [3:0] cand_cnt_r;
  state_t     state_r;

  logic       edge_s;
  logic [1:0] cls_s;
  logic       confirm_s;
  logic       silence_s;

  // Edge detect, run classification and confirmation/silence conditions
  always_comb begin
    edge_s = (s2_r != p_r);
    if (run_len_r == HI_LEN) begin
      cls_s = 2'b10;
    end else if (run_len_r == LO_LEN) begin
      cls_s = 2'b01;
    end else begin
      cls_s = 2'b00;
    end
    confirm_s = (cand_cnt_r == CONF_N) && (cand_r != tone) && (cand_r != 2'b00);
    silence_s = !edge_s && (run_len_r == SIL_LEN);
  end

  // Two-flop synchronizer followed by the previous-value register
  always_ff @(posedge clk) begin
    if (!st) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      p_r  <= 1'b0;
    end else begin
      s1_r <= beep_in;
      s2_r <= s1_r;
      p_r  <= s2_r;
    end
  end

  // Decoder state machine with registered outputs
  always_ff @(posedge clk) begin
    if (!st) begin
      tone         <= 2'b00;
      tone_chg     <= 1'b0;
      seg_cnt      <= 4'd0;
      err          <= 1'b0;
      done         <= 1'b0;
      state_r      <= IDLE;
      run_len_r    <= 8'd0;
      cand_r       <= 2'b00;
      cand_cnt_r   <= 4'd0;
      first_edge_r <= 1'b1;
    end else begin
      tone_chg <= 1'b0;
      err      <= 1'b0;
      case (state_r)
        DONE: begin
          tone <= 2'b00;
          done <= 1'b1;
        end
        IDLE, TRACK: begin
          if (edge_s) begin
            run_len_r <= 8'd1;
            if (first_edge_r) begin
              first_edge_r <= 1'b0;
            end else if (cls_s == 2'b00) begin
              err        <= 1'b1;
              cand_r     <= 2'b00;
              cand_cnt_r <= 4'd0;
            end else if (cls_s == cand_r) begin
              if (cand_cnt_r < CONF_N) begin
                cand_cnt_r <= cand_cnt_r + 4'd1;
              end else begin
                cand_cnt_r <= cand_cnt_r;
              end
            end else begin
              cand_r     <= cls_s;
              cand_cnt_r <= 4'd1;
            end
          end else if (silence_s) begin
            // Next edge after silence starts a fresh measurement
            first_edge_r <= 1'b1;
            cand_r       <= 2'b00;
            cand_cnt_r   <= 4'd0;
            if (tone != 2'b00) begin
              tone     <= 2'b00;
              tone_chg <= 1'b1;
              if (seg_cnt >= EXP_N) begin
                state_r <= DONE;
                done    <= 1'b1;
              end else begin
                state_r <= IDLE;
              end
            end else begin
              tone <= tone;
            end
          end else if (run_len_r < SIL_LEN) begin
            run_len_r <= run_len_r + 8'd1;
          end else begin
            run_len_r <= run_len_r;
          end
          // Confirmation uses the candidate as it stood before this edge
          if (confirm_s) begin
            tone     <= cand_r;
            tone_chg <= 1'b1;
            state_r  <= TRACK;
            if (seg_cnt != 4'd15) begin
              seg_cnt <= seg_cnt + 4'd1;
            end else begin
              seg_cnt <= seg_cnt;
            end
          end else begin
            seg_cnt <= seg_cnt;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_beep_decode.sv
// Self-checking bench for beep_decode: directed scenarios plus random tone
// patterns compared cycle by cycle against a timing-based reference model.
module tb_beep_decode;

  localparam int HI   = 1;
  localparam int LO   = 2;
  localparam int CONF = 4;
  localparam int SIL  = 16;
  localparam int EXP  = 4;

  logic       clk = 1'b0;
  logic       st = 1'b0;
  logic       beep_in = 1'b0;
  logic [1:0] tone;
  logic       tone_chg;
  logic [3:0] seg_cnt;
  logic       err;
  logic       done;

  beep_decode #(
    .HI_HALF(HI), .LO_HALF(LO), .CONF(CONF), .SIL_LIM(SIL), .EXPECT_SEG(EXP)
  ) dut (
    .clk(clk), .st(st), .beep_in(beep_in), .tone(tone), .tone_chg(tone_chg),
    .seg_cnt(seg_cnt), .err(err), .done(done)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Reference model: works from edge times and run-length streaks.
  int mk = 0;
  bit bh[$] = '{1'b0, 1'b0, 1'b0};
  int m_last = 1;
  bit m_first = 1'b1;
  int m_cls = 0;
  int m_len = 0;
  int m_tone = 0;
  int m_segs = 0;
  bit m_chg = 1'b0;
  bit m_err = 1'b0;
  bit m_done = 1'b0;

  task automatic mdl(input logic b, input logic s);
    int o_cls, o_len, o_tone, gap, c;
    bit ed;
    mk++;
    if (!s) begin
      bh = '{1'b0, 1'b0, 1'b0};
      m_last = mk + 1; m_first = 1'b1; m_cls = 0; m_len = 0; m_tone = 0;
      m_segs = 0; m_chg = 1'b0; m_err = 1'b0; m_done = 1'b0;
      return;
    end
    o_cls = m_cls; o_len = m_len; o_tone = m_tone;
    // beep_in seen two edges ago versus three edges ago
    ed = (bh[bh.size()-2] != bh[bh.size()-3]);
    gap = mk - m_last;
    bh.push_back(b);
    if (bh.size() > 8) void'(bh.pop_front());
    m_chg = 1'b0; m_err = 1'b0;
    if (m_done) return;
    if (ed) begin
      m_last = mk;
      if (m_first) m_first = 1'b0;
      else begin
        c = (gap == HI) ? 2 : ((gap == LO) ? 1 : 0);
        if (c == 0) begin m_err = 1'b1; m_cls = 0; m_len = 0; end
        else if (c == o_cls) m_len++;
        else begin m_cls = c; m_len = 1; end
      end
    end else if (gap >= SIL) begin
      m_first = 1'b1; m_cls = 0; m_len = 0;
      if (o_tone != 0) begin
        m_tone = 0; m_chg = 1'b1;
        if (m_segs >= EXP) m_done = 1'b1;
      end
    end
    if (o_len >= CONF && o_cls != o_tone) begin
      m_tone = o_cls; m_chg = 1'b1;
      if (m_segs < 15) m_segs++;
    end
  endtask

  function automatic logic [8:0] exp_v();
    return {2'(m_tone), m_chg, 4'(m_segs), m_err, m_done};
  endfunction

  task automatic step(input logic b, input logic s);
    beep_in = b;
    st = s;
    @(posedge clk);
    mdl(b, s);
    #1;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(~beep_in, 1'b0);
      nvec++;
      if ({tone, tone_chg, seg_cnt, err, done} !== 9'd0) begin
        nerr++;
        $display("FAIL reset cyc %0d: got %b want %b", i, {tone, tone_chg, seg_cnt, err, done}, 9'd0);
      end
    end
  endtask

  task automatic test_hi_tone();
    int nchg, chg_at, nerrp;
    nchg = 0; chg_at = -1; nerrp = 0;
    do_reset();
    for (int i = 0; i < 15; i++) begin
      step(~beep_in, 1'b1);
      nvec++;
      if ({tone, tone_chg, seg_cnt, err, done} !== exp_v()) begin
        nerr++;
        $display("FAIL hi_tone cyc %0d: got %b want %b", i, {tone, tone_chg, seg_cnt, err, done}, exp_v());
      end
      if (tone_chg === 1'b1) begin nchg++; chg_at = i; end
      if (err === 1'b1) nerrp++;
    end
    nvec++;
    if (nchg != 1 || chg_at != 7) begin
      nerr++;
      $display("FAIL hi_tone_latency: got %0d pulses last at %0d, want 1 at 7", nchg, chg_at);
    end
    nvec++;
    if (tone !== 2'b10 || seg_cnt !== 4'd1 || nerrp != 0) begin
      nerr++;
      $display("FAIL hi_tone_final: got tone %b seg %0d errs %0d, want 10 1 0", tone, seg_cnt, nerrp);
    end
  endtask

  task automatic test_generator();
    int g, last_tg, done_at;
    logic nb;
    int seq[$];
    g = 0; last_tg = -1; done_at = -1;
    do_reset();
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < 250 + 749; i++) begin
        nb = (i >= 250 || (i % 2) == 0) ? ~beep_in : beep_in;
        if (nb !== beep_in) last_tg = g;
        step(nb, 1'b1);
        nvec++;
        if ({tone, tone_chg, seg_cnt, err, done} !== exp_v()) begin
          nerr++;
          $display("FAIL gen cyc %0d: got %b want %b", g, {tone, tone_chg, seg_cnt, err, done}, exp_v());
        end
        if (tone_chg === 1'b1) seq.push_back(int'(tone));
        g++;
      end
    end
    for (int i = 0; i < 40; i++) begin
      if (beep_in !== 1'b0) last_tg = g;
      step(1'b0, 1'b1);
      nvec++;
      if ({tone, tone_chg, seg_cnt, err, done} !== exp_v()) begin
        nerr++;
        $display("FAIL gen_tail cyc %0d: got %b want %b", g, {tone, tone_chg, seg_cnt, err, done}, exp_v());
      end
      if (tone_chg === 1'b1) seq.push_back(int'(tone));
      if (done === 1'b1 && done_at < 0) done_at = g;
      g++;
    end
    nvec++;
    if (seq.size() != 5 || seq[0] != 1 || seq[1] != 2 || seq[2] != 1 || seq[3] != 2 || seq[4] != 0) begin
      nerr++;
      $display("FAIL gen_sequence: got %0d changes %p, want 1 2 1 2 0", seq.size(), seq);
    end
    nvec++;
    if (seg_cnt !== 4'd4 || done !== 1'b1 || tone !== 2'b00) begin
      nerr++;
      $display("FAIL gen_final: got seg %0d done %b tone %b, want 4 1 00", seg_cnt, done, tone);
    end
    nvec++;
    if (done_at - last_tg != 18) begin
      nerr++;
      $display("FAIL gen_silence_delay: got %0d cycles, want 18", done_at - last_tg);
    end
  endtask

  task automatic test_invalid();
    int errs, tone_nz;
    errs = 0; tone_nz = 0;
    do_reset();
    for (int i = 0; i < 66; i++) begin
      step((i < 60 && (i % 3) == 0) ? ~beep_in : beep_in, 1'b1);
      nvec++;
      if ({tone, tone_chg, seg_cnt, err, done} !== exp_v()) begin
        nerr++;
        $display("FAIL invalid cyc %0d: got %b want %b", i, {tone, tone_chg, seg_cnt, err, done}, exp_v());
      end
      if (err === 1'b1) errs++;
      if (tone !== 2'b00) tone_nz++;
    end
    nvec++;
    if (errs != 19 || tone_nz != 0 || seg_cnt !== 4'd0) begin
      nerr++;
      $display("FAIL invalid_summary: got errs %0d tone_nz %0d seg %0d, want 19 0 0", errs, tone_nz, seg_cnt);
    end
  endtask

  task automatic test_silence_idle();
    int chg_hi, chg_sil;
    chg_hi = -1; chg_sil = -1;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      step((i < 10) ? ~beep_in : beep_in, 1'b1);
      nvec++;
      if ({tone, tone_chg, seg_cnt, err, done} !== exp_v()) begin
        nerr++;
        $display("FAIL sil cyc %0d: got %b want %b", i, {tone, tone_chg, seg_cnt, err, done}, exp_v());
      end
      if (tone_chg === 1'b1 && tone === 2'b10) chg_hi = i;
      if (tone_chg === 1'b1 && tone === 2'b00) chg_sil = i;
    end
    nvec++;
    if (chg_hi != 7 || chg_sil != 27 || done !== 1'b0 || seg_cnt !== 4'd1) begin
      nerr++;
      $display("FAIL sil_timing: got hi %0d sil %0d done %b seg %0d, want 7 27 0 1", chg_hi, chg_sil, done, seg_cnt);
    end
    for (int i = 0; i < 15; i++) begin
      step(~beep_in, 1'b1);
      nvec++;
      if ({tone, tone_chg, seg_cnt, err, done} !== exp_v()) begin
        nerr++;
        $display("FAIL sil_burst cyc %0d: got %b want %b", i, {tone, tone_chg, seg_cnt, err, done}, exp_v());
      end
    end
    nvec++;
    if (seg_cnt !== 4'd2 || tone !== 2'b10 || done !== 1'b0) begin
      nerr++;
      $display("FAIL sil_second: got seg %0d tone %b done %b, want 2 10 0", seg_cnt, tone, done);
    end
  endtask

  task automatic test_midtone_reset();
    int chg_at;
    chg_at = -1;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      step((i < 10 || (i % 2) == 0) ? ~beep_in : beep_in, 1'b1);
      nvec++;
      if ({tone, tone_chg, seg_cnt, err, done} !== exp_v()) begin
        nerr++;
        $display("FAIL mid cyc %0d: got %b want %b", i, {tone, tone_chg, seg_cnt, err, done}, exp_v());
      end
    end
    nvec++;
    if (tone !== 2'b01 || seg_cnt !== 4'd2) begin
      nerr++;
      $display("FAIL mid_pre: got tone %b seg %0d, want 01 2", tone, seg_cnt);
    end
    step(1'b0, 1'b0);
    nvec++;
    if ({tone, tone_chg, seg_cnt, err, done} !== 9'd0) begin
      nerr++;
      $display("FAIL mid_reset: got %b want %b", {tone, tone_chg, seg_cnt, err, done}, 9'd0);
    end
    for (int i = 0; i < 20; i++) begin
      step(((i % 2) == 0) ? ~beep_in : beep_in, 1'b1);
      nvec++;
      if ({tone, tone_chg, seg_cnt, err, done} !== exp_v()) begin
        nerr++;
        $display("FAIL mid_restart cyc %0d: got %b want %b", i, {tone, tone_chg, seg_cnt, err, done}, exp_v());
      end
      if (tone_chg === 1'b1 && chg_at < 0) chg_at = i;
    end
    nvec++;
    if (chg_at != 11 || tone !== 2'b01 || seg_cnt !== 4'd1) begin
      nerr++;
      $display("FAIL mid_reconfirm: got chg at %0d tone %b seg %0d, want 11 01 1", chg_at, tone, seg_cnt);
    end
  endtask

  task automatic test_random();
    int mode, per, len;
    do_reset();
    for (int seg = 0; seg < 120; seg++) begin
      mode = $urandom_range(0, 9);
      per  = (mode < 4) ? 1 : ((mode < 8) ? 2 : ((mode == 8) ? $urandom_range(1, 5) : 0));
      len  = (per == 0) ? $urandom_range(5, 30) : $urandom_range(4, 40);
      if ($urandom_range(0, 29) == 0 || (m_done && $urandom_range(0, 2) == 0)) begin
        step(beep_in, 1'b0);
        nvec++;
        if ({tone, tone_chg, seg_cnt, err, done} !== exp_v()) begin
          nerr++;
          $display("FAIL rand_reset seg %0d: got %b want %b", seg, {tone, tone_chg, seg_cnt, err, done}, exp_v());
        end
      end
      for (int i = 0; i < len; i++) begin
        step((per != 0 && (i % per) == 0) ? ~beep_in : beep_in, 1'b1);
        nvec++;
        if ({tone, tone_chg, seg_cnt, err, done} !== exp_v()) begin
          nerr++;
          $display("FAIL rand seg %0d cyc %0d: got %b want %b", seg, i, {tone, tone_chg, seg_cnt, err, done}, exp_v());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_hi_tone();
    test_generator();
    test_invalid();
    test_silence_idle();
    test_midtone_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
